// File: rtl/avalon_write_buffer_pkg.sv
// Shared types for the data-side write buffer: Avalon request/response,
// buffered entry layout and the bus-hold state machine encoding.
package avalon_write_buffer_pkg;

  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byte_enable;
  } avalon_req_t;

  typedef struct packed {
    logic        waitrequest;
    logic [31:0] readdata;
  } avalon_resp_t;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wb_entry_t;

  typedef enum logic [1:0] {IDLE, WR_HOLD, RD_HOLD} state_t;

endpackage

// File: rtl/avalon_write_buffer_fifo.sv
// Circular store of posted writes with per-entry valid bits and a parallel
// word-address compare against every live entry.
module wbuf_fifo
  import avalon_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  wb_entry_t                i_entry,
  input  logic                     i_pop,
  input  logic [29:0]              i_match_addr,
  output wb_entry_t                o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_empty,
  output logic                     o_full,
  output logic                     o_match
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0]    r_head, r_tail;
  logic [PW:0]      r_count;
  logic [DEPTH-1:0] r_valid;
  wb_entry_t        r_mem [DEPTH];
  logic [DEPTH-1:0] w_hit;
  logic             w_push, w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_count = r_count;
  assign o_head  = r_mem[r_head];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      // push and pop never target the same slot: that needs empty or full
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= i_entry;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    assign w_hit[i] = r_valid[i] && (r_mem[i].addr == i_match_addr);
  end
  assign o_match = |w_hit;

endmodule

// File: rtl/avalon_write_buffer.sv
// Posted-write buffer between the D-cache memory port and the memory bus;
// reads bypass the drain unless they could observe a buffered word.
module avalon_write_buffer
  import avalon_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  avalon_req_t             cache_avn_req,
  output avalon_resp_t            cache_avn_resp,
  output avalon_req_t             mem_avn_req,
  input  avalon_resp_t            mem_avn_resp,
  output logic                    wb_empty,
  output logic [$clog2(DEPTH):0]  wb_count
);

  state_t    r_state, w_next;
  wb_entry_t w_entry, w_head;
  logic      w_rd, w_wr, w_rd_stall, w_fwd, w_drain, w_push, w_pop;
  logic      w_match, w_empty, w_full;

  assign w_entry = '{addr: cache_avn_req.address[31:2],
                     data: cache_avn_req.writedata,
                     be:   cache_avn_req.byte_enable};

  wbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_entry      (w_entry),
    .i_pop        (w_pop),
    .i_match_addr (cache_avn_req.address[31:2]),
    .o_head       (w_head),
    .o_count      (wb_count),
    .o_empty      (w_empty),
    .o_full       (w_full),
    .o_match      (w_match)
  );

  assign wb_empty = w_empty;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_rd       = cache_avn_req.read;
    w_wr       = cache_avn_req.write & ~cache_avn_req.read;
    // uncached reads must see every earlier write, so they wait for empty
    w_rd_stall = w_match | (cache_avn_req.address[31] & ~w_empty) | (r_state == WR_HOLD);
    w_fwd      = w_rd & ((r_state == RD_HOLD) | ~w_rd_stall);
    w_drain    = ~w_empty & ~w_fwd & (r_state != RD_HOLD);
    w_pop      = w_drain & ~mem_avn_resp.waitrequest;
    w_push     = w_wr & ~w_full;

    mem_avn_req = '0;
    if (w_fwd) begin
      mem_avn_req.read        = 1'b1;
      mem_avn_req.address     = cache_avn_req.address;
      mem_avn_req.byte_enable = cache_avn_req.byte_enable;
    end else if (w_drain) begin
      mem_avn_req.write       = 1'b1;
      mem_avn_req.address     = {w_head.addr, 2'b00};
      mem_avn_req.writedata   = w_head.data;
      mem_avn_req.byte_enable = w_head.be;
    end

    cache_avn_resp.readdata    = mem_avn_resp.readdata;
    cache_avn_resp.waitrequest = w_rd ? (w_fwd ? mem_avn_resp.waitrequest : 1'b1)
                                      : (w_wr & w_full);

    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_fwd && mem_avn_resp.waitrequest)        w_next = RD_HOLD;
        else if (w_drain && mem_avn_resp.waitrequest) w_next = WR_HOLD;
      end
      WR_HOLD: if (!mem_avn_resp.waitrequest)         w_next = IDLE;
      RD_HOLD: if (!w_fwd || !mem_avn_resp.waitrequest) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

endmodule
